piso_tx_reg: RTL and testbench
==============================

# piso_tx_reg

Parallel-in serial-out transmit register: the reading end of the team's 4-bit buffer register. It accepts a parallel word through a valid/ready handshake into a one-word holding buffer. It moves the word into a shift register and drives it out one bit per enabled cycle, LSB first. Back-to-back words stream with no idle cycle between frames. It sits between a parallel producer (buffer/controlled buffer register) and a serial link or SIPO receiver.

## Interface
- WIDTH, 4, word width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- in_valid  input  1  producer presents in_data
- in_data  input  WIDTH  parallel word
- in_ready  output  1  holding buffer empty; word accepted on edge when in_valid && in_ready
- tx_en  input  1  bit-rate enable; shifter advances only when high
- ser_out  output  1  current serial bit (0 when ser_valid low)
- ser_valid  output  1  ser_out carries a frame bit
- frame_start  output  1  high while ser_out is bit 0 of a frame
- word_done  output  1  one-cycle pulse after the last bit of a frame is consumed

## Operation
- Clock is clk; reset is rst, asynchronous and active-low. All state is cleared immediately on rst low, with no clock required.
- Reset values:
  - hold_full, ser_valid, frame_start, word_done, ser_out = 0.
  - in_ready = 1.
  - Shift register and bit counter = 0.
- Internal state:
  - hold register with hold_full flag.
  - shift register sh[WIDTH-1:0].
  - bit counter cnt, range 0..WIDTH-1, width $clog2(WIDTH).
  - state IDLE / SHIFT.
- in_ready = ~hold_full. It is combinational from a register, with no dependence on in_valid.
- Accept: the edge with in_valid && in_ready latches in_data into hold and sets hold_full.
- IDLE:
  - If hold_full, the next edge loads sh ← hold, clears hold_full, sets cnt=0, and goes to SHIFT.
  - The load ignores tx_en.
- SHIFT, on an edge with tx_en=1:
  - cnt<WIDTH-1: sh ← sh>>1, cnt++.
  - cnt==WIDTH-1, hold_full=1: reload sh ← hold, clear hold_full, cnt=0, pulse word_done, stay in SHIFT. This is the gapless case.
  - cnt==WIDTH-1, hold_full=0: go to IDLE and pulse word_done.
- SHIFT, on an edge with tx_en=0: sh, cnt and state hold.
- Output signals:
  - ser_valid = (state==SHIFT).
  - ser_out = sh[0] & ser_valid.
  - frame_start = ser_valid && cnt==0.
- Simultaneous accept and reload on one edge: not possible in the same edge, because accept requires hold empty and reload requires hold full. An accept on the edge right after a reload is legal.
- in_data is sampled only on the accept edge. Changes at other times are ignored.
- Mid-operation reset: the current frame and held word are discarded. ser_out and ser_valid drop to 0 asynchronously.

## Timing
- Accept at edge N → hold_full=1 after N.
  - If the shifter is idle: load at N+1; bit 0 visible after N+1 with frame_start=1.
- Frame length: exactly WIDTH tx_en-high cycles while in SHIFT.
- word_done rises after the edge that consumes bit WIDTH-1 and lasts one cycle.
- Sustained throughput with tx_en=1: one WIDTH-bit word per WIDTH cycles, provided the producer refills hold within WIDTH-1 cycles of each reload.
- in_ready returns to 1 the cycle after hold is transferred to the shifter.

## Structure
- Shared package: state encoding enum (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH constant, reused by the matching SIPO receiver.
- One natural sub-module: hold_buf, a WIDTH-bit load-enabled buffer register plus full flag, with async active-low reset. The shift/count FSM lives in the top module.

## Test plan
- Reset: assert rst=0 mid-frame with tx_en=1 → ser_valid, ser_out, word_done, frame_start = 0 and in_ready=1 immediately, without waiting for a clock edge.
- Single word: WIDTH=4, tx_en=1, send 4'b1011 → in_ready low 1 cycle; ser_out sequence 1,1,0,1 starting 2 edges after accept; frame_start on first bit only; word_done one cycle after the 4th bit; then IDLE.
- Back-to-back: send 4'hA, then 4'h5 while A is shifting → serial 0,1,0,1,1,0,1,0 with no gap; frame_start on bits 0 and 4; two word_done pulses.
- tx_en throttling: word 4'b0110 with tx_en toggling 1,0,1,0,… → each bit held 2 cycles; ser_out 0,0,1,1,1,1,0,0; cnt never advances on tx_en=0.
- Backpressure: hold in_valid=1 continuously with a shifting word plus a held word → in_ready=0 and in_data changes ignored; word sent matches the value at the accept edge.
- Idle output: no input after reset for 20 cycles → ser_out=0, ser_valid=0, in_ready=1 throughout.

Source files
------------

// File: rtl/piso_tx_reg_pkg.sv
// Shared definitions for the PISO transmit register and the matching SIPO
// receiver: shifter state encoding and the default word width.
package piso_tx_reg_pkg;

  // Default word width of the team's buffer register family.
  localparam int DEFAULT_WIDTH = 4;

  // Shifter state: IDLE waits for a held word, SHIFT drives frame bits.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of a bit counter that spans 0..width-1 (width >= 2).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_tx_reg_if.sv
// Parallel handshake and serial output bundle of the PISO transmit register.
// The producer/link side uses the master modport; the register uses slave.
interface piso_tx_reg_if
  import piso_tx_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             tx_en;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             word_done;

  modport master (
    output in_valid, in_data, tx_en,
    input  in_ready, ser_out, ser_valid, frame_start, word_done
  );

  modport slave (
    input  in_valid, in_data, tx_en,
    output in_ready, ser_out, ser_valid, frame_start, word_done
  );

endinterface

// File: rtl/piso_tx_reg_hold_buf.sv
// One-word holding buffer: WIDTH-bit load-enabled register plus full flag.
// load writes a new word and marks it full; take hands the word over and
// frees the slot. The two never coincide because load needs an empty slot
// and take needs a full one.
module piso_tx_reg_hold_buf
  import piso_tx_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  // Buffer register and occupancy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the data register is reset as well, so a discarded word can
      // never reappear after reset and nothing downstream ever sees X.
      data <= '0;
      full <= 1'b0;
    end else if (load) begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge value, independent of statement order.
      data <= load_data;
      full <= 1'b1;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_tx_reg.sv
// Parallel-in serial-out transmit register. Words enter a one-word holding
// buffer through a valid/ready handshake, move into a shift register and
// leave LSB first, one bit per tx_en cycle. A word waiting in the buffer is
// reloaded on the edge that consumes the last bit, so frames stream gaplessly.
module piso_tx_reg
  import piso_tx_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  piso_tx_reg_if.slave bus
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             transfer;

  // A word is taken whenever the producer offers one and the buffer is empty.
  assign accept = bus.in_valid && !hold_full;

  piso_tx_reg_hold_buf #(
    .WIDTH (WIDTH)
  ) u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (bus.in_data),
    .take      (transfer),
    .data      (hold_data),
    .full      (hold_full)
  );

  // Next-state logic: load from idle, shift, and reload or stop at frame end.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    transfer = 1'b0;

    case (state_q)
      IDLE: begin
        // The initial load does not wait for tx_en.
        if (hold_full) begin
          sh_d     = hold_data;
          cnt_d    = '0;
          transfer = 1'b1;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.tx_en) begin
          if (cnt_q != LAST_CNT) begin
            sh_d  = sh_q >> 1;
            cnt_d = cnt_q + 1'b1;
          end else begin
            done_d = 1'b1;
            if (hold_full) begin
              // Gapless case: next word's bit 0 follows directly.
              sh_d     = hold_data;
              cnt_d    = '0;
              transfer = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  // Shifter, bit counter, state and frame-end pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Outputs are decoded straight from registers; in_ready ignores in_valid.
  assign bus.in_ready    = ~hold_full;
  assign bus.ser_valid   = (state_q == SHIFT);
  assign bus.ser_out     = sh_q[0] & bus.ser_valid;
  assign bus.frame_start = bus.ser_valid && (cnt_q == '0);
  assign bus.word_done   = done_q;

  // Accept needs an empty buffer, transfer a full one: never both at once.
  a_no_accept_and_transfer : assert property (
    @(posedge clk) disable iff (!rst) !(accept && transfer)
  );

  // frame_start only ever marks a real frame bit.
  a_frame_start_in_frame : assert property (
    @(posedge clk) disable iff (!rst) bus.frame_start |-> bus.ser_valid
  );

endmodule

// File: tb/tb_piso_tx_reg.sv
// Self-checking bench for piso_tx_reg. The reference model is a queue of
// accepted words, each tagged with the first edge after which it may appear
// on the serial line; the monitor walks through those words bit by bit.
module tb_piso_tx_reg;
  import piso_tx_reg_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  typedef struct {
    logic [W-1:0] data;
    int           avail;  // bits may appear after this edge index
  } word_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  piso_tx_reg_if #(.WIDTH(W)) bus ();

  piso_tx_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_checks     = 0;
  int    n_pass       = 0;
  int    edge_cnt     = 0;
  int    bidx         = 0;
  logic  done_pending = 1'b0;
  word_t q[$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
  endtask

  // Buffer is occupied by any word not yet moved into the shifter: a second
  // queued word, or a lone word whose load edge has not yet happened.
  function automatic logic model_ready();
    if (q.size() >= 2) return 1'b0;
    if (q.size() == 1 && q[0].avail > edge_cnt) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: compare outputs mid-cycle, then consume a bit if tx_en is high.
  initial begin
    logic exp_valid;
    logic exp_bit;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bidx         = 0;
        done_pending = 1'b0;
      end else begin
        exp_valid = (q.size() > 0) && (q[0].avail <= edge_cnt);
        exp_bit   = exp_valid ? q[0].data[bidx] : 1'b0;
        check("ser_valid",   bus.ser_valid,   exp_valid);
        check("ser_out",     bus.ser_out,     exp_bit);
        check("frame_start", bus.frame_start, exp_valid && (bidx == 0));
        check("word_done",   bus.word_done,   done_pending);
        check("in_ready",    bus.in_ready,    model_ready());
        done_pending = 1'b0;
        if (exp_valid && bus.tx_en) begin
          bidx++;
          if (bidx == W) begin
            void'(q.pop_front());
            bidx         = 0;
            done_pending = 1'b1;
          end
        end
      end
    end
  end

  // Drive one cycle of stimulus; record the word if the model accepts it.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic te);
    logic acc;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.tx_en    = te;
    acc = v && model_ready();
    @(posedge clk);
    #1;
    if (acc) q.push_back('{data: d, avail: edge_cnt + 1});
  endtask

  task automatic idle_cycles(input int n, input logic te);
    for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), te);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q.size() > 0 || done_pending); i++)
      cycle(1'b0, W'($urandom), 1'b1);
    idle_cycles(2, 1'b1);
  endtask

  initial begin
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.tx_en    = 1'b0;

    // Reset state, before any clock edge.
    #2;
    check("rst_ser_valid",   bus.ser_valid,   1'b0);
    check("rst_ser_out",     bus.ser_out,     1'b0);
    check("rst_frame_start", bus.frame_start, 1'b0);
    check("rst_word_done",   bus.word_done,   1'b0);
    check("rst_in_ready",    bus.in_ready,    1'b1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Idle output for 20 cycles.
    idle_cycles(20, 1'b1);

    // Single word 1011.
    cycle(1'b1, 4'b1011, 1'b1);
    drain();

    // Back-to-back: A, then 5 while A is shifting.
    cycle(1'b1, 4'hA, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b1, 4'h5, 1'b1);
    drain();

    // tx_en throttling on 0110.
    cycle(1'b1, 4'b0110, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'h0, (i % 2) == 0);
    drain();

    // Backpressure: in_valid held high with changing data.
    for (int i = 0; i < 30; i++) cycle(1'b1, W'($urandom), 1'b1);
    drain();

    // Random traffic with random tx_en.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3) != 0);
    drain();

    // Mid-frame reset with a word shifting and another held.
    cycle(1'b1, 4'h9, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b1, 4'h3, 1'b1);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    q.delete();
    #1;
    check("midrst_ser_valid",   bus.ser_valid,   1'b0);
    check("midrst_ser_out",     bus.ser_out,     1'b0);
    check("midrst_frame_start", bus.frame_start, 1'b0);
    check("midrst_word_done",   bus.word_done,   1'b0);
    check("midrst_in_ready",    bus.in_ready,    1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // Traffic after reset recovers normally.
    idle_cycles(3, 1'b1);
    cycle(1'b1, 4'hC, 1'b1);
    cycle(1'b1, 4'h7, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
